// File: rtl/seg_scan_ctrl.sv
// Scan controller for a multiplexed 7-segment display sharing one BCD decoder.
// Blanking gap before each digit; new words are double-buffered to frame boundaries.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLANK_CYC   = 500
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           load,
  input  logic [4*NUM_DIGITS-1:0]        value_bcd,
  input  logic                           blank_lz,
  output logic                           s3,
  output logic                           s2,
  output logic                           s1,
  output logic                           s0,
  output logic [NUM_DIGITS-1:0]          an_n,
  output logic [$clog2(NUM_DIGITS)-1:0]  digit_idx,
  output logic                           frame_start,
  output logic                           bcd_err
);

  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx_d;
  logic [4*NUM_DIGITS-1:0] active, active_d;
  logic [4*NUM_DIGITS-1:0] shadow, shadow_d;
  logic                    pending, pending_d;
  logic                    commit;
  logic [4*NUM_DIGITS-1:0] commit_word;
  logic                    fs_d;
  logic                    err_d;
  logic [NUM_DIGITS-1:0]   dark;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   an_d;
  logic [3:0]              s_d, s_q;

  function automatic logic has_bad_nibble(input logic [4*NUM_DIGITS-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++)
      if (w[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    idx_d       = digit_idx;
    shadow_d    = shadow;
    pending_d   = pending;
    commit      = 1'b0;
    commit_word = value_bcd;
    fs_d        = 1'b0;
    unique case (state)
      IDLE: begin
        if (load) begin
          commit  = 1'b1;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = BLANK;
          fs_d    = 1'b1;
        end
      end
      BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          cnt_d   = '0;
          state_d = SHOW;
        end else begin
          cnt_d = cnt + 1'b1;
        end
        if (load) begin
          shadow_d  = value_bcd;
          pending_d = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == CW'(REFRESH_DIV - 1) && digit_idx == IW'(NUM_DIGITS - 1)) begin
          // Frame boundary: a load on this very cycle beats the shadow.
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = BLANK;
          fs_d      = 1'b1;
          pending_d = 1'b0;
          if (load) begin
            commit = 1'b1;
          end else if (pending) begin
            commit      = 1'b1;
            commit_word = shadow;
          end
        end else begin
          if (cnt == CW'(REFRESH_DIV - 1)) begin
            cnt_d   = '0;
            idx_d   = digit_idx + 1'b1;
            state_d = BLANK;
          end else begin
            cnt_d = cnt + 1'b1;
          end
          if (load) begin
            shadow_d  = value_bcd;
            pending_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    active_d = commit ? commit_word : active;
    err_d    = bcd_err | (commit & has_bad_nibble(commit_word));
  end

  // Outputs are registered from next-state values so they line up with the state.
  always_comb begin
    dark     = '0;
    zero_run = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run & (active_d[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      if (i != NUM_DIGITS - 1)
        dark[NUM_DIGITS-1-i] = blank_lz & zero_run;
    end
    an_d = '1;
    if (state_d == SHOW && !dark[idx_d])
      an_d[idx_d] = 1'b0;
    s_d = (state_d == IDLE) ? 4'd0 : active_d[{idx_d, 2'b00} +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      digit_idx   <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      bcd_err     <= 1'b0;
      an_n        <= '1;
      s_q         <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      digit_idx   <= idx_d;
      active      <= active_d;
      shadow      <= shadow_d;
      pending     <= pending_d;
      frame_start <= fs_d;
      bcd_err     <= err_d;
      an_n        <= an_d;
      s_q         <= s_d;
    end
  end

  assign {s3, s2, s1, s0} = s_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl (4 digits, 4-cycle show, 2-cycle blank).
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_bcd = '0;
  logic        blank_lz = 1'b0;
  logic        s3, s2, s1, s0;
  logic [3:0]  an_n;
  logic [1:0]  digit_idx;
  logic        frame_start;
  logic        bcd_err;

  seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYC(2)) dut (
    .clk(clk), .rst(rst), .load(load), .value_bcd(value_bcd), .blank_lz(blank_lz),
    .s3(s3), .s2(s2), .s1(s1), .s0(s0), .an_n(an_n), .digit_idx(digit_idx),
    .frame_start(frame_start), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [3:0] s;
    logic [1:0] idx;
    logic       fs;
    logic       err;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push_exp(input int c, input logic [3:0] an, input logic [3:0] s,
                          input logic [1:0] idx, input logic fs, input logic err,
                          input int limit, input string tag);
    exp_t e;
    if (c < limit) begin
      e.cyc = c; e.an = an; e.s = s; e.idx = idx; e.fs = fs; e.err = err; e.tag = tag;
      q.push_back(e);
    end
  endtask

  // Two blank-cycle checks and first/last show-cycle checks per digit slot.
  task automatic push_frame(input int p, input logic [15:0] w, input logic [3:0] lit,
                            input logic err, input int limit, input string tag);
    for (int k = 0; k < 4; k++) begin
      int         base;
      logic [3:0] nib;
      logic [3:0] an_show;
      logic [1:0] ki;
      base    = p + 6 * k;
      nib     = w[4*k +: 4];
      ki      = 2'(k);
      an_show = lit[k] ? ~(4'b0001 << k) : 4'b1111;
      push_exp(base,     4'hF,    nib, ki, (k == 0), err, limit, tag);
      push_exp(base + 1, 4'hF,    nib, ki, 1'b0,     err, limit, tag);
      push_exp(base + 2, an_show, nib, ki, 1'b0,     err, limit, tag);
      push_exp(base + 5, an_show, nib, ki, 1'b0,     err, limit, tag);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      logic [11:0] got, want;
      e    = q.pop_front();
      got  = {an_n, s3, s2, s1, s0, digit_idx, frame_start, bcd_err};
      want = {e.an, e.s, e.idx, e.fs, e.err};
      n_total++;
      if (e.cyc != cyc)
        $display("FAIL %s cyc%0d: check missed (now cyc %0d)", e.tag, e.cyc, cyc);
      else if (got !== want)
        $display("FAIL %s cyc%0d: got an_n=%b s=%h idx=%0d fs=%b err=%b, want an_n=%b s=%h idx=%0d fs=%b err=%b",
                 e.tag, e.cyc, an_n, {s3, s2, s1, s0}, digit_idx, frame_start, bcd_err,
                 e.an, e.s, e.idx, e.fs, e.err);
      else
        n_pass++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got cyc=%0d want end", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int p, p2;
    // 1: reset, then idle
    for (int c = 1; c <= 22; c++) push_exp(c, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1 << 30, "idle");
    wait_until(2);
    rst = 1'b0;

    // 2: first load from IDLE, two full frames queued (second carries the shadow)
    wait_until(22);
    p = 23;
    push_frame(p,      16'h1234, 4'b1111, 1'b0, 1 << 30, "frame1234");
    push_frame(p + 24, 16'h9999, 4'b1111, 1'b0, 1 << 30, "frame9999");
    load = 1'b1; value_bcd = 16'h1234;
    @(negedge clk); load = 1'b0;

    // 3: two mid-frame loads, last one wins at the boundary
    wait_until(p + 7);
    load = 1'b1; value_bcd = 16'h5678;
    @(negedge clk); load = 1'b0;
    wait_until(p + 13);
    load = 1'b1; value_bcd = 16'h9999;
    @(negedge clk); load = 1'b0;

    // 4: load on the boundary cycle with leading-zero suppression
    wait_until(p + 47);
    push_frame(p + 48, 16'h0070, 4'b0011, 1'b0, 1 << 30, "frame0070lz");
    blank_lz = 1'b1;
    load = 1'b1; value_bcd = 16'h0070;
    @(negedge clk); load = 1'b0;

    // 5: invalid BCD sets sticky error; a clean word afterwards keeps it
    wait_until(p + 49);
    push_frame(p + 72, 16'h00A0, 4'b0011, 1'b1, 1 << 30, "frame00A0");
    load = 1'b1; value_bcd = 16'h00A0;
    @(negedge clk); load = 1'b0;
    wait_until(p + 73);
    push_frame(p + 96, 16'h0000, 4'b0001, 1'b1, p + 111, "frame0000");
    load = 1'b1; value_bcd = 16'h0000;
    @(negedge clk); load = 1'b0;

    // 6: reset during digit 2 SHOW with a pending shadow
    wait_until(p + 97);
    load = 1'b1; value_bcd = 16'h4321;
    @(negedge clk); load = 1'b0;
    wait_until(p + 110);
    push_exp(p + 111, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1 << 30, "rst");
    for (int c = p + 112; c <= p + 115; c++)
      push_exp(c, 4'hF, 4'h0, 2'd0, 1'b0, 1'b0, 1 << 30, "idle_after_rst");
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    wait_until(p + 115);
    p2 = p + 116;
    push_frame(p2,      16'h0005, 4'b1111, 1'b0, 1 << 30, "frame0005");
    push_frame(p2 + 24, 16'h0005, 4'b1111, 1'b0, 1 << 30, "frame0005b");
    blank_lz = 1'b0;
    load = 1'b1; value_bcd = 16'h0005;
    @(negedge clk); load = 1'b0;

    wait_until(p2 + 50);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_total++;
      $display("FAIL %s cyc%0d: never checked, got no sample want one", e.tag, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
